// File: rtl/btn_debounce_pulse.sv
// Push-button conditioner: two-flop synchroniser, debounce FSM with a
// stability counter, one-cycle press strobe and optional hold-to-repeat.
// The strobe is the advance enable for the downstream Gray counter.
module btn_debounce_pulse #(
    parameter int DELAY  = 4,   // consecutive stable cycles needed to accept a change
    parameter int CW     = 8,   // width of the stability and repeat counters
    parameter int REPEAT = 0    // auto-repeat period while held, 0 = off
) (
    input  logic clk,
    input  logic rst,           // asynchronous, active low
    input  logic btw,           // raw bouncing button line
    output logic btn_level,
    output logic btn_pulse,
    output logic busy
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ARMING    = 2'd1,
        HELD      = 2'd2,
        RELEASING = 2'd3
    } state_t;

    localparam logic [CW-1:0] ONE       = CW'(1);
    localparam logic [CW-1:0] STAB_LAST = CW'(DELAY - 1);
    localparam logic [CW-1:0] REP_LAST  = (REPEAT > 0) ? CW'(REPEAT - 1) : '0;
    // With DELAY=1 the first stable sample is already enough, so the
    // qualifying states are skipped entirely.
    localparam bit            FAST      = (DELAY == 1);
    localparam bit            REP_EN    = (REPEAT != 0);

    logic          s1_q, s2_q;
    state_t        state_q, state_d;
    logic [CW-1:0] stab_q, stab_d;
    logic [CW-1:0] rep_q, rep_d;
    logic          level_q, level_d;
    logic          pulse_q, pulse_d;
    logic          busy_q, busy_d;

    // Two-flop synchroniser for the asynchronous button line.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= btw;
            s2_q <= s1_q;
        end
    end

    // Next-state, counter and output decode for the debounce FSM.
    always_comb begin
        state_d = state_q;
        stab_d  = stab_q;
        rep_d   = rep_q;
        level_d = level_q;
        pulse_d = 1'b0;
        case (state_q)
            IDLE: begin
                level_d = 1'b0;
                if (s2_q) begin
                    if (FAST) begin
                        state_d = HELD;
                        level_d = 1'b1;
                        pulse_d = 1'b1;
                        rep_d   = '0;
                        stab_d  = '0;
                    end else begin
                        state_d = ARMING;
                        stab_d  = ONE;
                    end
                end
            end
            ARMING: begin
                if (!s2_q) begin
                    // Bounce: went low before the press was qualified.
                    state_d = IDLE;
                    stab_d  = '0;
                end else if (stab_q == STAB_LAST) begin
                    state_d = HELD;
                    level_d = 1'b1;
                    pulse_d = 1'b1;
                    rep_d   = '0;
                    stab_d  = '0;
                end else begin
                    stab_d = stab_q + ONE;
                end
            end
            HELD: begin
                if (!s2_q) begin
                    if (FAST) begin
                        state_d = IDLE;
                        level_d = 1'b0;
                        stab_d  = '0;
                    end else begin
                        state_d = RELEASING;
                        stab_d  = ONE;
                    end
                end else if (REP_EN) begin
                    // The pulse_q guard keeps strobes apart when REPEAT=1,
                    // turning it into a repeat every second cycle.
                    if (rep_q == REP_LAST) begin
                        if (!pulse_q) begin
                            pulse_d = 1'b1;
                            rep_d   = '0;
                        end
                    end else begin
                        rep_d = rep_q + ONE;
                    end
                end
            end
            RELEASING: begin
                if (s2_q) begin
                    // Release glitch: resume the hold, repeat phase preserved.
                    state_d = HELD;
                    stab_d  = '0;
                end else if (stab_q == STAB_LAST) begin
                    state_d = IDLE;
                    level_d = 1'b0;
                    stab_d  = '0;
                end else begin
                    stab_d = stab_q + ONE;
                end
            end
            default: begin
                state_d = IDLE;
                stab_d  = '0;
                rep_d   = '0;
                level_d = 1'b0;
            end
        endcase
        busy_d = (state_d == ARMING) || (state_d == RELEASING);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            stab_q  <= '0;
            rep_q   <= '0;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            stab_q  <= stab_d;
            rep_q   <= rep_d;
            level_q <= level_d;
            pulse_q <= pulse_d;
            busy_q  <= busy_d;
        end
    end

    assign btn_level = level_q;
    assign btn_pulse = pulse_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// Directed bench: instance A (DELAY=4, no repeat) and instance B
// (DELAY=4, REPEAT=8) share clock and reset; each has its own button line.
module tb_btn_debounce_pulse;

    logic clk = 1'b0;
    logic rst;
    logic btw_a, btw_b;
    logic level_a, pulse_a, busy_a;
    logic level_b, pulse_b, busy_b;

    btn_debounce_pulse #(.DELAY(4), .CW(8), .REPEAT(0)) dut_a (
        .clk       (clk),
        .rst       (rst),
        .btw       (btw_a),
        .btn_level (level_a),
        .btn_pulse (pulse_a),
        .busy      (busy_a)
    );

    btn_debounce_pulse #(.DELAY(4), .CW(8), .REPEAT(8)) dut_b (
        .clk       (clk),
        .rst       (rst),
        .btw       (btw_b),
        .btn_level (level_b),
        .btn_pulse (pulse_b),
        .busy      (busy_b)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int ecount = 0;       // number of the edge the next tick() will consume
    int pulses_a = 0, pulses_b = 0;
    int last_pa = -10, last_pb = -10;
    int doubles = 0;      // back-to-back pulse occurrences on either instance
    int busy_hi_a = 0, level_hi_a = 0, lowlev_b = 0;
    int pb_edges[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock edge; sample outputs 1 time unit later and account for pulses.
    task automatic tick();
        @(posedge clk);
        #1;
        if (pulse_a === 1'b1) begin
            if (last_pa == ecount - 1) doubles++;
            pulses_a++;
            last_pa = ecount;
        end
        if (pulse_b === 1'b1) begin
            if (last_pb == ecount - 1) doubles++;
            pulses_b++;
            last_pb = ecount;
            pb_edges.push_back(ecount);
        end
        if (busy_a === 1'b1)  busy_hi_a++;
        if (level_a === 1'b1) level_hi_a++;
        if (level_b !== 1'b1) lowlev_b++;
        ecount++;
    endtask

    task automatic drive_a(input logic v, input int n);
        for (int i = 0; i < n; i++) begin
            btw_a = v;
            tick();
        end
    endtask

    task automatic drive_b(input logic v, input int n);
        for (int i = 0; i < n; i++) begin
            btw_b = v;
            tick();
        end
    endtask

    initial begin
        int e0, p0, lv0, bz0, lb0;

        // ---------------- reset ----------------
        rst   = 1'b1;
        btw_a = 1'b0;
        btw_b = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("rst_level_a", level_a, 0);
        check("rst_pulse_a", pulse_a, 0);
        check("rst_busy_a",  busy_a,  0);
        check("rst_level_b", level_b, 0);
        btw_a = 1'b1;
        tick(); tick(); tick();
        check("rst_hold_level_a", level_a, 0);
        check("rst_hold_busy_a",  busy_a,  0);
        rst   = 1'b1;
        btw_a = 1'b0;
        drive_a(0, 4);
        check("idle_level_a", level_a, 0);
        check("idle_busy_a",  busy_a,  0);
        check("idle_pulses_a", pulses_a, 0);

        // ---------------- clean press ----------------
        e0 = ecount; p0 = pulses_a;
        drive_a(1, 2);
        check("press_e1_busy", busy_a, 0);
        drive_a(1, 3);
        check("press_e4_level", level_a, 0);
        check("press_e4_pulse", pulse_a, 0);
        check("press_e4_busy",  busy_a,  1);
        drive_a(1, 1);
        check("press_e5_level", level_a, 1);
        check("press_e5_pulse", pulse_a, 1);
        check("press_e5_busy",  busy_a,  0);
        check("press_pulse_edge", last_pa - e0, 5);
        drive_a(1, 1);
        check("press_e6_pulse", pulse_a, 0);
        drive_a(1, 13);
        check("press_hold_level", level_a, 1);
        check("press_pulse_count", pulses_a - p0, 1);
        drive_a(0, 5);
        check("release_r4_level", level_a, 1);
        check("release_r4_busy",  busy_a,  1);
        drive_a(0, 1);
        check("release_r5_level", level_a, 0);
        check("release_r5_pulse", pulse_a, 0);
        check("release_r5_busy",  busy_a,  0);
        drive_a(0, 4);
        check("release_pulse_count", pulses_a - p0, 1);

        // ---------------- reset during hold ----------------
        drive_a(1, 8);
        check("hold_before_rst_level", level_a, 1);
        p0 = pulses_a;
        rst = 1'b0;
        #1;
        check("async_rst_level", level_a, 0);
        check("async_rst_pulse", pulse_a, 0);
        check("async_rst_busy",  busy_a,  0);
        #3 rst = 1'b1;
        e0 = ecount;
        drive_a(1, 5);
        check("requal_e4_level", level_a, 0);
        check("requal_e4_pulse", pulse_a, 0);
        drive_a(1, 1);
        check("requal_e5_level", level_a, 1);
        check("requal_e5_pulse", pulse_a, 1);
        check("requal_pulse_edge", last_pa - e0, 5);
        check("requal_pulse_count", pulses_a - p0, 1);
        drive_a(0, 10);

        // ---------------- bounce rejection ----------------
        p0 = pulses_a; lv0 = level_hi_a; bz0 = busy_hi_a;
        drive_a(1, 3);
        check("bounce_arming_busy", busy_a, 1);
        drive_a(0, 1);
        drive_a(1, 2);
        check("bounce_rejected_busy", busy_a, 0);
        drive_a(0, 9);
        check("bounce_pulses",     pulses_a - p0,   0);
        check("bounce_level_hi",   level_hi_a - lv0, 0);
        check("bounce_busy_cycles", busy_hi_a - bz0, 5);

        // ---------------- bounce then settle ----------------
        e0 = ecount; p0 = pulses_a;
        drive_a(1, 3);
        drive_a(0, 1);
        drive_a(1, 2);
        drive_a(0, 1);
        drive_a(1, 10);
        check("settle_pulse_count", pulses_a - p0, 1);
        check("settle_pulse_edge",  last_pa - e0, 12);
        check("settle_level",       level_a, 1);
        drive_a(0, 10);
        check("settle_release_level", level_a, 0);

        // ---------------- auto-repeat ----------------
        e0 = ecount;
        pb_edges.delete();
        drive_b(1, 40);
        check("rep_count", pb_edges.size(), 5);
        check("rep_first_edge", pb_edges[0] - e0, 5);
        check("rep_second_edge", pb_edges[1] - e0, 13);
        check("rep_last_edge",  pb_edges[4] - e0, 37);
        drive_b(0, 10);
        check("rep_release_level", level_b, 0);

        // Hold with a two-cycle release glitch: repeat phase pauses, no loss.
        e0 = ecount; lb0 = lowlev_b;
        pb_edges.delete();
        drive_b(1, 15);
        drive_b(0, 2);
        drive_b(1, 23);
        check("glitch_level_low_cycles", lowlev_b - lb0, 5);
        check("glitch_pulse_count", pb_edges.size(), 4);
        check("glitch_third_edge", pb_edges[2] - e0, 24);
        check("glitch_fourth_edge", pb_edges[3] - e0, 32);
        drive_b(0, 10);
        check("glitch_release_level", level_b, 0);

        // ---------------- press sequence ----------------
        p0 = pulses_a;
        for (int k = 0; k < 32; k++) begin
            drive_a(1, 8);
            drive_a(0, 8);
        end
        check("seq_pulse_count", pulses_a - p0, 32);
        check("seq_final_level", level_a, 0);
        check("no_double_pulses", doubles, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
